// File: rtl/mem_access_unit_if.sv
// Data-bus side of the load/store unit: valid/ready request channel with
// byte strobes and same-cycle read data.
interface mem_access_unit_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  bus_valid;
    logic                  bus_ready;
    logic                  bus_write;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [XLEN-1:0]       bus_wdata;
    logic [XLEN/8-1:0]     bus_wstrb;
    logic [XLEN-1:0]       bus_rdata;

    modport master (
        output bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_write, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: stalls the executor while a valid/ready bus
// access is outstanding, builds byte strobes and sign/zero-extends loads.
module mem_access_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  wait_sig,
    output logic                  done,
    output logic [XLEN-1:0]       rdata,
    output logic                  fault,
    output logic                  timeout_err,
    mem_access_unit_if.master     bus
);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t          state, state_n;
    logic [OW-1:0]   off_q;
    logic [2:0]      f3_q;
    logic [CW-1:0]   cnt;

    logic            req_illegal, req_misaligned;
    logic            start_req, fault_n, tmo_n, load_done;
    int unsigned     req_off, req_nbytes;
    logic [NB-1:0]   req_strb;
    logic [XLEN-1:0] req_wrep;
    int unsigned     ld_bits;
    logic            ld_sign;
    logic [XLEN-1:0] ld_shift, ld_ext;

    // Legality and alignment of the incoming request
    always_comb begin
        req_illegal    = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
        if (XLEN == 32 && (req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110))
            req_illegal = 1'b1;
        req_misaligned = 1'b0;
        case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = |req_addr[1:0];
            2'b11:   req_misaligned = |req_addr[2:0];
            default: req_misaligned = 1'b0;
        endcase
    end

    // Strobe mask and lane replication of the right-aligned store data
    always_comb begin
        req_off    = 32'(req_addr[OW-1:0]);
        req_nbytes = 1 << req_funct3[1:0];
        if (req_nbytes > NB)
            req_nbytes = NB;
        req_strb = '0;
        req_wrep = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            req_strb[i] = (i >= req_off) && (i < req_off + req_nbytes);
            for (int unsigned j = 0; j < NB; j++)
                if (j == i % req_nbytes)
                    req_wrep[8*i +: 8] = req_wdata[8*j +: 8];
        end
    end

    // Load path: shift the addressed bytes down, then extend from the top data bit
    always_comb begin
        ld_shift = bus.bus_rdata >> {off_q, 3'b000};
        ld_bits  = 8 << f3_q[1:0];
        if (ld_bits > XLEN)
            ld_bits = XLEN;
        ld_sign = 1'b0;
        for (int unsigned i = 0; i < XLEN; i++)
            if (i == ld_bits - 1)
                ld_sign = ld_shift[i] & ~f3_q[2];
        ld_ext = '0;
        for (int unsigned i = 0; i < XLEN; i++)
            ld_ext[i] = (i < ld_bits) ? ld_shift[i] : ld_sign;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n   = state;
        start_req = 1'b0;
        fault_n   = 1'b0;
        tmo_n     = 1'b0;
        load_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_illegal || req_misaligned) begin
                        state_n = DONE;
                        fault_n = 1'b1;
                    end else begin
                        state_n   = REQ;
                        start_req = 1'b1;
                    end
                end
            end
            REQ: begin
                // A ready arriving with the final count still completes normally
                if (bus.bus_ready) begin
                    state_n   = DONE;
                    load_done = ~bus.bus_write;
                end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
                    state_n = DONE;
                    tmo_n   = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_q         <= '0;
            f3_q          <= '0;
            cnt           <= '0;
            bus.bus_write <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            bus.bus_wstrb <= '0;
            rdata         <= '0;
            fault         <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            fault       <= fault_n;
            timeout_err <= tmo_n;
            rdata       <= load_done ? ld_ext : '0;
            if (start_req) begin
                off_q         <= req_addr[OW-1:0];
                f3_q          <= req_funct3;
                cnt           <= '0;
                bus.bus_write <= req_write;
                bus.bus_addr  <= {req_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
                bus.bus_wdata <= req_wrep;
                bus.bus_wstrb <= req_write ? req_strb : '0;
            end else if (state == REQ && !bus.bus_ready) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.bus_valid = (state == REQ);
    assign done          = (state == DONE);
    assign wait_sig      = ((state == IDLE) && req_valid) || (state == REQ);
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: an XLEN=32 unit with a short timeout
// and an XLEN=64 unit, driven from a shared vector table.
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sel64, req_valid, req_write, bus_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, bus_rdata;

    logic        w32, d32, f32, t32, w64, d64, f64, t64;
    logic [31:0] r32;
    logic [63:0] r64;
    logic        rv32, rv64;

    assign rv32 = req_valid & ~sel64;
    assign rv64 = req_valid & sel64;

    mem_access_unit_if #(.XLEN(32), .ADDR_WIDTH(32)) bus32 ();
    mem_access_unit_if #(.XLEN(64), .ADDR_WIDTH(32)) bus64 ();

    assign bus32.bus_ready = bus_ready & ~sel64;
    assign bus32.bus_rdata = bus_rdata[31:0];
    assign bus64.bus_ready = bus_ready & sel64;
    assign bus64.bus_rdata = bus_rdata;

    mem_access_unit #(.XLEN(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) u32 (
        .clk(clk), .rst(rst), .req_valid(rv32), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
        .wait_sig(w32), .done(d32), .rdata(r32), .fault(f32), .timeout_err(t32),
        .bus(bus32)
    );

    mem_access_unit #(.XLEN(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(255)) u64 (
        .clk(clk), .rst(rst), .req_valid(rv64), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .wait_sig(w64), .done(d64), .rdata(r64), .fault(f64), .timeout_err(t64),
        .bus(bus64)
    );

    logic        o_wait, o_done, o_fault, o_tmo, o_bvalid, o_bwrite;
    logic [31:0] o_baddr;
    logic [7:0]  o_strb;
    logic [63:0] o_rdata, o_bwdata;

    assign o_wait   = sel64 ? w64 : w32;
    assign o_done   = sel64 ? d64 : d32;
    assign o_fault  = sel64 ? f64 : f32;
    assign o_tmo    = sel64 ? t64 : t32;
    assign o_rdata  = sel64 ? r64 : {32'h0, r32};
    assign o_bvalid = sel64 ? bus64.bus_valid : bus32.bus_valid;
    assign o_bwrite = sel64 ? bus64.bus_write : bus32.bus_write;
    assign o_baddr  = sel64 ? bus64.bus_addr  : bus32.bus_addr;
    assign o_strb   = sel64 ? bus64.bus_wstrb : {4'h0, bus32.bus_wstrb};
    assign o_bwdata = sel64 ? bus64.bus_wdata : {32'h0, bus32.bus_wdata};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        bit          sel64;
        bit          wr;
        bit [2:0]    f3;
        bit [31:0]   addr;
        bit [63:0]   wdata;
        bit [63:0]   brdata;
        int unsigned waits;
        bit          tmo;
        bit          flt;
        bit [31:0]   baddr;
        bit [7:0]    strb;
        bit [63:0]   bwdata;
        bit [63:0]   rdata;
    } vec_t;

    vec_t vecs[$];

    // One access from request (cycle 0) through done; req_valid held until done.
    task automatic run(input vec_t v);
        int unsigned n_req;
        bit          ok;
        logic [31:0] a0;
        logic [7:0]  s0;
        logic [63:0] d0;
        logic        w0;
        @(negedge clk);
        sel64      = v.sel64;
        req_write  = v.wr;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        bus_rdata  = v.brdata;
        bus_ready  = 1'b0;
        req_valid  = 1'b1;
        #1;
        chk({v.name, ".wait0"}, 64'(o_wait), 64'(1));
        chk({v.name, ".idle"}, {62'h0, o_bvalid, o_done}, 64'h0);
        if (v.flt) begin
            @(posedge clk); #1;
            chk({v.name, ".fault_done"}, {61'h0, o_done, o_fault, o_tmo}, 64'b110);
            chk({v.name, ".fault_bus"}, {62'h0, o_bvalid, o_wait}, 64'h0);
            chk({v.name, ".fault_rdata"}, o_rdata, 64'h0);
        end else begin
            n_req = v.tmo ? 4 : v.waits + 1;
            ok = 1'b1;
            a0 = '0; s0 = '0; d0 = '0; w0 = 1'b0;
            for (int unsigned c = 1; c <= n_req; c++) begin
                @(posedge clk); #1;
                if (!o_bvalid || !o_wait || o_done)
                    ok = 1'b0;
                if (c == 1) begin
                    a0 = o_baddr; s0 = o_strb; d0 = o_bwdata; w0 = o_bwrite;
                    chk({v.name, ".baddr"}, 64'(o_baddr), 64'(v.baddr));
                    chk({v.name, ".wstrb"}, 64'(o_strb), 64'(v.strb));
                    chk({v.name, ".bwdata"}, o_bwdata, v.bwdata);
                    chk({v.name, ".bwrite"}, 64'(o_bwrite), 64'(v.wr));
                end else if (o_baddr !== a0 || o_strb !== s0 || o_bwdata !== d0 || o_bwrite !== w0) begin
                    ok = 1'b0;
                end
                if (!v.tmo && c == n_req)
                    bus_ready = 1'b1;
            end
            chk({v.name, ".req_phase"}, 64'(ok), 64'(1));
            @(posedge clk); #1;
            bus_ready = 1'b0;
            chk({v.name, ".done"}, {61'h0, o_done, o_fault, o_tmo}, {61'h0, 1'b1, 1'b0, v.tmo});
            chk({v.name, ".rdata"}, o_rdata, v.rdata);
            chk({v.name, ".done_bus"}, {62'h0, o_bvalid, o_wait}, 64'h0);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        bit saw_done;
        sel64 = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; bus_ready = 1'b0; bus_rdata = '0;

        //          name       64 wr f3      addr          wdata                   brdata                 wt tmo flt baddr         strb    bwdata                  rdata
        vecs.push_back('{"lb",    0, 0, 3'b000, 32'h103, 64'h0,                  64'h80FF_1234,          0, 0, 0, 32'h100, 8'h00, 64'h0,                  64'hFFFF_FF80});
        vecs.push_back('{"lbu",   0, 0, 3'b100, 32'h103, 64'h0,                  64'h80FF_1234,          0, 0, 0, 32'h100, 8'h00, 64'h0,                  64'h0000_0080});
        vecs.push_back('{"sh",    0, 1, 3'b001, 32'h22,  64'hDEAD_BEEF,          64'h0,                  3, 0, 0, 32'h20,  8'h0C, 64'hBEEF_BEEF,          64'h0});
        vecs.push_back('{"lw_mis",0, 0, 3'b010, 32'h101, 64'h0,                  64'h0,                  0, 0, 1, 32'h0,   8'h00, 64'h0,                  64'h0});
        vecs.push_back('{"lh",    0, 0, 3'b001, 32'h102, 64'h0,                  64'h80FF_1234,          1, 0, 0, 32'h100, 8'h00, 64'h0,                  64'hFFFF_80FF});
        vecs.push_back('{"lhu",   0, 0, 3'b101, 32'h102, 64'h0,                  64'h80FF_1234,          0, 0, 0, 32'h100, 8'h00, 64'h0,                  64'h0000_80FF});
        vecs.push_back('{"sb",    0, 1, 3'b000, 32'h41,  64'h1234_5678,          64'h0,                  0, 0, 0, 32'h40,  8'h02, 64'h7878_7878,          64'h0});
        vecs.push_back('{"sw",    0, 1, 3'b010, 32'h10,  64'hCAFE_F00D,          64'h0,                  2, 0, 0, 32'h10,  8'h0F, 64'hCAFE_F00D,          64'h0});
        vecs.push_back('{"lw",    0, 0, 3'b010, 32'h8,   64'h0,                  64'h89AB_CDEF,          0, 0, 0, 32'h8,   8'h00, 64'h0,                  64'h89AB_CDEF});
        vecs.push_back('{"tmo",   0, 0, 3'b010, 32'h200, 64'h0,                  64'h1234_5678,          0, 1, 0, 32'h200, 8'h00, 64'h0,                  64'h0});
        vecs.push_back('{"tmo_rdy",0,0, 3'b010, 32'h204, 64'h0,                  64'h0000_0055,          3, 0, 0, 32'h204, 8'h00, 64'h0,                  64'h0000_0055});
        vecs.push_back('{"sh_mis",0, 1, 3'b001, 32'h21,  64'h1111,               64'h0,                  0, 0, 1, 32'h0,   8'h00, 64'h0,                  64'h0});
        vecs.push_back('{"ld32",  0, 0, 3'b011, 32'h0,   64'h0,                  64'h0,                  0, 0, 1, 32'h0,   8'h00, 64'h0,                  64'h0});
        vecs.push_back('{"st_ill",0, 1, 3'b100, 32'h0,   64'h0,                  64'h0,                  0, 0, 1, 32'h0,   8'h00, 64'h0,                  64'h0});
        vecs.push_back('{"lw64",  1, 0, 3'b010, 32'h44,  64'h0,                  64'h8000_0001_0000_0000,0, 0, 0, 32'h40,  8'h00, 64'h0,                  64'hFFFF_FFFF_8000_0001});
        vecs.push_back('{"lwu64", 1, 0, 3'b110, 32'h44,  64'h0,                  64'h8000_0001_0000_0000,0, 0, 0, 32'h40,  8'h00, 64'h0,                  64'h0000_0000_8000_0001});
        vecs.push_back('{"sd64",  1, 1, 3'b011, 32'h48,  64'h0123_4567_89AB_CDEF,64'h0,                  1, 0, 0, 32'h48,  8'hFF, 64'h0123_4567_89AB_CDEF,64'h0});
        vecs.push_back('{"ld_mis",1, 0, 3'b011, 32'h44,  64'h0,                  64'h0,                  0, 0, 1, 32'h0,   8'h00, 64'h0,                  64'h0});
        vecs.push_back('{"sw64",  1, 1, 3'b010, 32'h44,  64'h1122_3344_AABB_CCDD,64'h0,                  0, 0, 0, 32'h40,  8'hF0, 64'hAABB_CCDD_AABB_CCDD,64'h0});

        rst = 1'b1;
        #1;
        chk("reset.ctrl32", {59'h0, d32, f32, t32, bus32.bus_valid, bus32.bus_write}, 64'h0);
        chk("reset.bus32", {bus32.bus_addr, bus32.bus_wdata} | 64'(bus32.bus_wstrb), 64'h0);
        chk("reset.rdata32", 64'(r32), 64'h0);
        chk("reset.ctrl64", {59'h0, d64, f64, t64, bus64.bus_valid, bus64.bus_write}, 64'h0);
        chk("reset.bus64", bus64.bus_wdata | {bus64.bus_addr, 24'h0, bus64.bus_wstrb} | r64, 64'h0);
        chk("reset.wait", {62'h0, w32, w64}, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            run(vecs[i]);

        // Reset while the bus request is outstanding
        @(negedge clk);
        sel64 = 1'b0; req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30;
        req_wdata = 64'h5555_AAAA; bus_ready = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        chk("rstreq.valid_before", 64'(o_bvalid), 64'(1));
        @(posedge clk); #2;
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rstreq.valid_dropped", 64'(o_bvalid), 64'(0));
        chk("rstreq.cleared", {o_strb, o_baddr}, 64'h0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (o_done) saw_done = 1'b1;
        end
        chk("rstreq.no_done", 64'(saw_done), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        @(posedge clk); #1;
        if (o_done || o_bvalid) saw_done = 1'b1;
        chk("rstreq.quiet_after", 64'(saw_done), 64'(0));

        run('{"sw_after", 0, 1, 3'b010, 32'h30, 64'h5555_AAAA, 64'h0, 0, 0, 0, 32'h30, 8'h0F, 64'h5555_AAAA, 64'h0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
